multicycle_controller: RTL and testbench

Multi-cycle control FSM for the RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback, and drives the same datapath strobes as the single-cycle main controller. It adds a memory ready handshake with a wait timeout, pipeline-freeze stall handling, and an illegal-opcode trap. It sits between the instruction register and the PC/regfile/ALU/data-memory enables.

---
 rtl/ctrl_pkg.sv | 42 ++++
 rtl/ctrl_decode.sv | 30 +++
 rtl/multicycle_controller.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants and types for the multi-cycle RV32I controller.
package ctrl_pkg;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OP_L    = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    // ALU operation select
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
    localparam logic [1:0] ALUOP_PASS   = 2'b11;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StTrap   = 3'd6
    } state_e;

    // Instruction class; J covers JAL/JALR, U covers LUI
    typedef enum logic [2:0] {
        ClsNone = 3'd0,
        ClsL    = 3'd1,
        ClsS    = 3'd2,
        ClsR    = 3'd3,
        ClsI    = 3'd4,
        ClsB    = 3'd5,
        ClsJ    = 3'd6,
        ClsU    = 3'd7
    } op_class_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier.
// Optional build macro: CTRL_JUMP_EN makes JAL, JALR and LUI legal.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_e  op_class,
    output logic       legal
);

    // Map opcode to its class; anything unrecognised is ClsNone
    always_comb begin
        op_class = ClsNone;
        case (opcode)
            OP_L:    op_class = ClsL;
            OP_S:    op_class = ClsS;
            OP_R:    op_class = ClsR;
            OP_I:    op_class = ClsI;
            OP_B:    op_class = ClsB;
`ifdef CTRL_JUMP_EN
            OP_JAL:  op_class = ClsJ;
            OP_JALR: op_class = ClsJ;
            OP_LUI:  op_class = ClsU;
`endif
            default: op_class = ClsNone;
        endcase
        legal = (op_class != ClsNone);
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a memory
// ready timeout, stall freeze in DECODE/EXEC and an illegal-opcode trap.
// Optional build macro: CTRL_JUMP_EN (handled inside ctrl_decode).
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       stall,
    input  logic       mem_ready,
    output logic       fetch_req,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic       memread,
    output logic       memwrite,
    output logic       memtoreg,
    output logic       alusrc,
    output logic       regwrite,
    output logic [1:0] aluop,
    output logic       jump,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [2:0] state
);

    localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    logic [6:0]       opcode_q, opcode_d;
    op_class_e        cls_q, cls_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;

    op_class_e        dec_cls;
    logic             dec_legal;

    ctrl_decode u_decode (
        .opcode   (opcode),
        .op_class (dec_cls),
        .legal    (dec_legal)
    );

    // Next-state, capture and wait-counter logic
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        cls_d     = cls_q;
        cnt_d     = '0;  // zero outside FETCH/MEM, so every entry starts cleared
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        unique case (state_q)
            StIdle: begin
                if (!stall) state_d = StFetch;
            end
            StFetch: begin
                if (mem_ready) begin
                    state_d = StDecode;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = StTrap;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDecode: begin
                if (!stall) begin
                    if (dec_legal) begin
                        state_d  = StExec;
                        opcode_d = opcode;
                        cls_d    = dec_cls;
                    end else begin
                        state_d   = StTrap;
                        illegal_d = 1'b1;
                    end
                end
            end
            StExec: begin
                if (!stall) begin
                    unique case (cls_q)
                        ClsL, ClsS:             state_d = StMem;
                        ClsR, ClsI, ClsJ, ClsU: state_d = StWb;
                        ClsB:                   state_d = StFetch;
                        default: begin
                            state_d   = StTrap;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
            end
            StMem: begin
                if (mem_ready) begin
                    state_d = (cls_q == ClsL) ? StWb : StFetch;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = StTrap;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StWb:    state_d = StFetch;
            StTrap:  state_d = StTrap;
            default: state_d = StIdle;
        endcase
    end

    // Datapath strobes decoded from state and the captured instruction class
    always_comb begin
        fetch_req = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        branch    = 1'b0;
        memread   = 1'b0;
        memwrite  = 1'b0;
        memtoreg  = 1'b0;
        alusrc    = 1'b0;
        regwrite  = 1'b0;
        aluop     = ALUOP_ADD;
        jump      = 1'b0;
        unique case (state_q)
            StFetch: begin
                fetch_req = 1'b1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            StExec: begin
                if (!stall) begin
                    unique case (cls_q)
                        ClsL, ClsS, ClsI: alusrc = 1'b1;
                        ClsR:             aluop  = ALUOP_FUNCT;
                        ClsB: begin
                            branch = 1'b1;
                            aluop  = ALUOP_BRANCH;
                        end
                        ClsJ: begin
                            jump     = 1'b1;
                            pc_write = 1'b1;
                            alusrc   = (opcode_q == OP_JALR);
                        end
                        ClsU: begin
                            alusrc = 1'b1;
                            aluop  = ALUOP_PASS;
                        end
                        default: ;
                    endcase
                end
            end
            StMem: begin
                memread  = (cls_q == ClsL);
                memwrite = (cls_q == ClsS);
            end
            StWb: begin
                regwrite = 1'b1;
                memtoreg = (cls_q == ClsL);
            end
            default: ;
        endcase
    end

    // State register; reset drops any in-flight request immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            opcode_q  <= '0;
            cls_q     <= ClsNone;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            cls_q     <= cls_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    assign illegal_op  = illegal_q;
    assign mem_timeout = timeout_q;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: each instruction is expanded
// into an expected per-cycle timeline from the phase rules, then driven and compared.
module tb_multicycle_controller;

    localparam int unsigned TO = 15;

    localparam logic [6:0] L_OP   = 7'b0000011;
    localparam logic [6:0] S_OP   = 7'b0100011;
    localparam logic [6:0] R_OP   = 7'b0110011;
    localparam logic [6:0] I_OP   = 7'b0010011;
    localparam logic [6:0] B_OP   = 7'b1100011;
    localparam logic [6:0] JAL_OP = 7'b1101111;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DEC = 3'd2, S_EXEC = 3'd3;
    localparam logic [2:0] S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6;

    // Strobe vector: {fetch_req, ir_write, pc_write, branch, memread, memwrite,
    //                 memtoreg, alusrc, regwrite, aluop[1:0], jump}
    localparam logic [11:0] FR    = 12'h800, IRW = 12'h400, PCW  = 12'h200, BR   = 12'h100;
    localparam logic [11:0] MRD   = 12'h080, MWR = 12'h040, MTR  = 12'h020, ASRC = 12'h010;
    localparam logic [11:0] RW    = 12'h008, AO_BR = 12'h002, AO_FN = 12'h004;
    localparam logic [11:0] JMP   = 12'h001, NONE = 12'h000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       stall, mem_ready;
    logic       fetch_req, ir_write, pc_write, branch, memread, memwrite;
    logic       memtoreg, alusrc, regwrite, jump, illegal_op, mem_timeout;
    logic [1:0] aluop;
    logic [2:0] state;

    int  errors = 0;
    int  checks = 0;
    logic exp_ill, exp_to;

    multicycle_controller #(.MEM_TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .stall       (stall),
        .mem_ready   (mem_ready),
        .fetch_req   (fetch_req),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .branch      (branch),
        .memread     (memread),
        .memwrite    (memwrite),
        .memtoreg    (memtoreg),
        .alusrc      (alusrc),
        .regwrite    (regwrite),
        .aluop       (aluop),
        .jump        (jump),
        .illegal_op  (illegal_op),
        .mem_timeout (mem_timeout),
        .state       (state)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] strobes();
        return {fetch_req, ir_write, pc_write, branch, memread, memwrite,
                memtoreg, alusrc, regwrite, aluop, jump};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected EXEC strobes per opcode
    function automatic logic [11:0] exec_vec(input logic [6:0] op);
        case (op)
            L_OP, S_OP, I_OP: return ASRC;
            R_OP:             return AO_FN;
            B_OP:             return BR | AO_BR;
`ifdef CTRL_JUMP_EN
            JAL_OP:           return JMP | PCW;
            7'b1100111:       return JMP | PCW | ASRC;
            7'b0110111:       return ASRC | 12'h006;
`endif
            default:          return NONE;
        endcase
    endfunction

    function automatic logic has_wb(input logic [6:0] op);
`ifdef CTRL_JUMP_EN
        if (op == JAL_OP || op == 7'b1100111 || op == 7'b0110111) return 1'b1;
`endif
        return (op == L_OP || op == R_OP || op == I_OP);
    endfunction

    // Outputs must match the all-quiet reset picture right now (no clock edge)
    task automatic check_now(input string tag);
        checks++;
        assert (state === S_IDLE) else begin
            errors++;
            $error("FAIL %s state: observed %0d expected %0d", tag, state, S_IDLE);
        end
        checks++;
        assert (strobes() === NONE) else begin
            errors++;
            $error("FAIL %s strobes: observed %h expected %h", tag, strobes(), NONE);
        end
        checks++;
        assert ({illegal_op, mem_timeout} === 2'b00) else begin
            errors++;
            $error("FAIL %s flags: observed %b expected 00", tag, {illegal_op, mem_timeout});
        end
    endtask

    // One clock cycle: drive inputs, compare at negedge, advance past posedge
    task automatic cycle(input logic st, input logic rdy, input logic [2:0] es,
                         input logic [11:0] ev, input string tag);
        stall     = st;
        mem_ready = rdy;
        @(negedge clk);
        checks++;
        assert (state === es) else begin
            errors++;
            $error("FAIL %s state: observed %0d expected %0d", tag, state, es);
        end
        checks++;
        assert (strobes() === ev) else begin
            errors++;
            $error("FAIL %s strobes: observed %h expected %h", tag, strobes(), ev);
        end
        checks++;
        assert ({illegal_op, mem_timeout} === {exp_ill, exp_to}) else begin
            errors++;
            $error("FAIL %s flags: observed %b expected %b", tag,
                   {illegal_op, mem_timeout}, {exp_ill, exp_to});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        stall = 1'b0;
        #3;
        check_now("reset_async");
        exp_ill = 1'b0;
        exp_to  = 1'b0;
        @(posedge clk);
        #2;
        check_now("reset_hold");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Full legal instruction starting in FETCH: fw fetch waits, mw mem waits,
    // ds/es stall cycles in DECODE/EXEC
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw,
                             input int ds, input int es, input string tag);
        logic [11:0] mv;
        opcode = 7'($urandom);
        for (int i = 0; i < fw; i++) cycle(rb(), 1'b0, S_FETCH, FR, tag);
        cycle(rb(), 1'b1, S_FETCH, FR | IRW | PCW, tag);
        opcode = op;
        for (int i = 0; i < ds; i++) cycle(1'b1, rb(), S_DEC, NONE, tag);
        cycle(1'b0, rb(), S_DEC, NONE, tag);
        opcode = 7'($urandom);  // EXEC onward must use the captured opcode
        for (int i = 0; i < es; i++) cycle(1'b1, rb(), S_EXEC, NONE, tag);
        cycle(1'b0, rb(), S_EXEC, exec_vec(op), tag);
        if (op == L_OP || op == S_OP) begin
            mv = (op == L_OP) ? MRD : MWR;
            for (int i = 0; i < mw; i++) cycle(rb(), 1'b0, S_MEM, mv, tag);
            cycle(rb(), 1'b1, S_MEM, mv, tag);
        end
        if (has_wb(op)) cycle(rb(), rb(), S_WB, RW | ((op == L_OP) ? MTR : NONE), tag);
    endtask

    initial begin
        logic [6:0] ops [5];
        ops[0] = L_OP; ops[1] = S_OP; ops[2] = R_OP; ops[3] = I_OP; ops[4] = B_OP;
        opcode  = '0;
        exp_ill = 1'b0;
        exp_to  = 1'b0;

        do_reset();
        cycle(1'b1, 1'b1, S_IDLE, NONE, "idle_stall");
        cycle(1'b0, 1'b0, S_IDLE, NONE, "idle");

        run_instr(R_OP, 0, 0, 0, 0, "r_zero");
        run_instr(L_OP, 0, 3, 0, 0, "ld_wait3");
        run_instr(B_OP, 0, 0, 2, 0, "br_stall2");
        run_instr(I_OP, TO, 0, 0, 0, "fetch_edge");
        run_instr(S_OP, 0, TO, 0, 1, "store_edge");

        for (int n = 0; n < 40; n++) begin
            int fw, mw;
            fw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TO)) : int'($urandom_range(0, 2));
            mw = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TO)) : int'($urandom_range(0, 2));
            run_instr(ops[$urandom_range(0, 4)], fw, mw, $urandom_range(0, 2),
                      $urandom_range(0, 2), "random");
        end

        // Fetch never answered: one wait too many traps
        for (int i = 0; i <= int'(TO); i++) cycle(rb(), 1'b0, S_FETCH, FR, "fetch_to");
        exp_to = 1'b1;
        for (int i = 0; i < 6; i++) cycle(rb(), rb(), S_TRAP, NONE, "to_trap");

        do_reset();
        cycle(1'b0, 1'b0, S_IDLE, NONE, "idle2");
        cycle(1'b0, 1'b1, S_FETCH, FR | IRW | PCW, "fetch2");
        opcode = 7'b1111111;
        cycle(1'b0, rb(), S_DEC, NONE, "dec_illegal");
        exp_ill = 1'b1;
        for (int i = 0; i < 20; i++) begin
            opcode = 7'($urandom);
            cycle(rb(), rb(), S_TRAP, NONE, "ill_trap");
        end

        do_reset();
        cycle(1'b0, 1'b0, S_IDLE, NONE, "idle3");
`ifdef CTRL_JUMP_EN
        run_instr(JAL_OP, 0, 0, 0, 0, "jal");
        run_instr(7'b1100111, 1, 0, 0, 0, "jalr");
        run_instr(7'b0110111, 0, 0, 0, 0, "lui");
`else
        cycle(1'b0, 1'b1, S_FETCH, FR | IRW | PCW, "fetch_jal");
        opcode = JAL_OP;
        cycle(1'b0, 1'b0, S_DEC, NONE, "dec_jal");
        exp_ill = 1'b1;
        for (int i = 0; i < 3; i++) cycle(rb(), rb(), S_TRAP, NONE, "jal_trap");
        do_reset();
        cycle(1'b0, 1'b0, S_IDLE, NONE, "idle4");
`endif

        // Store caught in MEM by an asynchronous reset
        cycle(1'b0, 1'b1, S_FETCH, FR | IRW | PCW, "fetch_st");
        opcode = S_OP;
        cycle(1'b0, 1'b0, S_DEC, NONE, "dec_st");
        cycle(1'b0, 1'b0, S_EXEC, ASRC, "exec_st");
        stall = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        assert (memwrite === 1'b1 && state === S_MEM) else begin
            errors++;
            $error("FAIL st_mem memwrite/state: observed %b/%0d expected 1/%0d",
                   memwrite, state, S_MEM);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_now("async_drop");
        @(posedge clk);
        #1;
        check_now("idle_edge");
        rst_n = 1'b1;
        exp_ill = 1'b0;
        exp_to  = 1'b0;
        cycle(1'b0, 1'b0, S_IDLE, NONE, "idle_after");
        cycle(1'b0, 1'b0, S_FETCH, FR, "fetch_after");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
